// File: rtl/caesar_stepper_encoder.sv
// caesar_stepper_encoder
// Encrypts one plaintext ASCII letter per keypress with a stepping Caesar
// rotor. Non-letters pass through unchanged and do not step the rotor.
//
// Handshake: there is no valid/ready pair on the input side. A keypress is
// accepted only on a clean 0->1 edge of key_press seen in IDLE. The output
// side is a push-only strobe: out_valid is high for exactly one cycle when
// enc_out takes a new value, and there is no back-pressure.
module caesar_stepper_encoder #(
    parameter logic [4:0] ROTOR_RESET = 5'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       key_press,
    input  logic       set_rotor,
    input  logic [4:0] rotor_init,
    output logic [7:0] enc_out,
    output logic       out_valid,
    output logic [4:0] rotor_out,
    output logic [7:0] char_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ENCRYPT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    state_t     state;
    logic       key_q;
    logic       release_seen;
    logic [7:0] char_reg;

    logic       key_edge;
    logic [4:0] rotor_load;
    logic       is_upper;
    logic       is_lower;
    logic       is_letter;
    logic [7:0] base;
    logic [7:0] offset;
    logic [5:0] sum6;
    logic [5:0] wrapped;
    logic [7:0] enc_char;

    // A held key across reset has never been seen low, so it cannot fake an
    // edge once reset lifts; release_seen blocks it until a real release.
    assign key_edge = key_press && !key_q && release_seen;

    // Load value reduced into 0..25.
    assign rotor_load = (rotor_init >= 5'd26) ? (rotor_init - 5'd26) : rotor_init;

    // Letter classification and modular shift of the captured character.
    always_comb begin
        is_upper  = (char_reg >= 8'd65) && (char_reg <= 8'd90);
        is_lower  = (char_reg >= 8'd97) && (char_reg <= 8'd122);
        is_letter = is_upper || is_lower;
        base      = is_lower ? 8'd97 : 8'd65;
        offset    = char_reg - base;
        sum6      = {1'b0, offset[4:0]} + {1'b0, rotor_out};
        wrapped   = (sum6 >= 6'd26) ? (sum6 - 6'd26) : sum6;
        enc_char  = is_letter ? (base + {3'b000, wrapped[4:0]}) : char_reg;
    end

    // Control FSM with registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            key_q        <= 1'b0;
            release_seen <= 1'b0;
            char_reg     <= 8'd0;
            enc_out      <= 8'd0;
            out_valid    <= 1'b0;
            rotor_out    <= ROTOR_RESET;
            char_count   <= 8'd0;
            busy         <= 1'b0;
        end else begin
            key_q     <= key_press;
            out_valid <= 1'b0;
            if (!key_press) begin
                release_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (set_rotor) begin
                        // Loading wins over a coincident keypress edge.
                        rotor_out  <= rotor_load;
                        char_count <= 8'd0;
                    end else if (key_edge) begin
                        char_reg <= char_in;
                        state    <= ENCRYPT;
                        busy     <= 1'b1;
                    end
                end
                ENCRYPT: begin
                    enc_out   <= enc_char;
                    out_valid <= 1'b1;
                    if (is_letter) begin
                        rotor_out <= (rotor_out == 5'd25) ? 5'd0 : (rotor_out + 5'd1);
                        if (char_count != 8'd255) begin
                            char_count <= char_count + 8'd1;
                        end
                    end
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!key_press) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_caesar_stepper_encoder.sv
// Bench for caesar_stepper_encoder: directed steps followed by randomized
// keypresses, checked against a behavioural Caesar model kept in the bench.
module tb_caesar_stepper_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] char_in;
    logic       key_press;
    logic       set_rotor;
    logic [4:0] rotor_init;
    logic [7:0] enc_out;
    logic       out_valid;
    logic [4:0] rotor_out;
    logic [7:0] char_count;
    logic       busy;

    int vectors;
    int miscompares;

    // Reference model state
    int m_rotor;
    int m_count;
    int m_enc;

    caesar_stepper_encoder #(.ROTOR_RESET(5'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .key_press  (key_press),
        .set_rotor  (set_rotor),
        .rotor_init (rotor_init),
        .enc_out    (enc_out),
        .out_valid  (out_valid),
        .rotor_out  (rotor_out),
        .char_count (char_count),
        .busy       (busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: apply one keypress worth of plaintext to the model state.
    task automatic model_key(input int c);
        if (c >= 65 && c <= 90) begin
            m_enc   = 65 + ((c - 65) + m_rotor) % 26;
            m_rotor = (m_rotor + 1) % 26;
            m_count = (m_count < 255) ? m_count + 1 : 255;
        end else if (c >= 97 && c <= 122) begin
            m_enc   = 97 + ((c - 97) + m_rotor) % 26;
            m_rotor = (m_rotor + 1) % 26;
            m_count = (m_count < 255) ? m_count + 1 : 255;
        end else begin
            m_enc = c;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".enc_out"}, int'(enc_out), m_enc);
        check({tag, ".rotor"}, int'(rotor_out), m_rotor);
        check({tag, ".count"}, int'(char_count), m_count);
    endtask

    // Driver: load the rotor while idle.
    task automatic load_rotor(input int v);
        set_rotor  = 1'b1;
        rotor_init = 5'(v);
        step();
        set_rotor  = 1'b0;
        m_rotor    = v % 26;
        m_count    = 0;
        check("load.rotor", int'(rotor_out), m_rotor);
        check("load.count", int'(char_count), 0);
    endtask

    // Driver: press a key for hold cycles, release, and check one encryption.
    task automatic press(input logic [7:0] c, input int hold, input string tag);
        int pulses;
        int busy_ok;
        pulses    = 0;
        busy_ok   = 1;
        char_in   = c;
        key_press = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (out_valid) pulses++;
            if (!busy) busy_ok = 0;
        end
        key_press = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid) pulses++;
        end
        model_key(int'(c));
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".busy_held"}, busy_ok, 1);
        check({tag, ".busy_idle"}, int'(busy), 0);
        check_state(tag);
    endtask

    initial begin
        int pulses;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        char_in     = 8'd0;
        key_press   = 1'b0;
        set_rotor   = 1'b0;
        rotor_init  = 5'd0;
        m_rotor = 0; m_count = 0; m_enc = 0;
        repeat (3) step();

        // Reset values
        check("rst.valid", int'(out_valid), 0);
        check("rst.busy", int'(busy), 0);
        check_state("rst");
        reset = 1'b1;
        repeat (2) step();

        // Basic sequence: rotor 3, ABC -> DFH
        load_rotor(3);
        press("A", 1, "abc_a");
        check("abc_a.lit", int'(enc_out), 68);
        press("B", 2, "abc_b");
        check("abc_b.lit", int'(enc_out), 70);
        press("C", 1, "abc_c");
        check("abc_c.lit", int'(enc_out), 72);
        check("abc.rotor_lit", int'(rotor_out), 6);
        check("abc.count_lit", int'(char_count), 3);

        // Wrap and case
        load_rotor(25);
        press("Z", 1, "wrap_z");
        check("wrap_z.lit", int'(enc_out), 89);
        check("wrap_z.rotor_lit", int'(rotor_out), 0);
        press("a", 1, "wrap_a");
        check("wrap_a.lit", int'(enc_out), 97);
        check("wrap_a.rotor_lit", int'(rotor_out), 1);

        // Non-letter pass-through
        load_rotor(5);
        press("1", 1, "digit");
        check("digit.lit", int'(enc_out), 49);
        check("digit.rotor_lit", int'(rotor_out), 5);
        check("digit.count_lit", int'(char_count), 0);

        // Held key: 20 cycles, exactly one encryption
        load_rotor(0);
        press("A", 20, "held");
        check("held.lit", int'(enc_out), 65);

        // Load reduction 30 -> 4
        load_rotor(30);
        check("mod.lit", int'(rotor_out), 4);

        // set_rotor during WAIT_RELEASE is ignored
        char_in   = "B";
        key_press = 1'b1;
        repeat (3) step();
        set_rotor  = 1'b1;
        rotor_init = 5'd10;
        repeat (2) step();
        set_rotor = 1'b0;
        key_press = 1'b0;
        repeat (3) step();
        model_key(int'("B"));
        check_state("wr_load");
        check("wr_load.rotor_lit", int'(rotor_out), 5);

        // set_rotor coincident with a key edge: load wins, no encryption
        pulses     = 0;
        char_in    = "C";
        key_press  = 1'b1;
        set_rotor  = 1'b1;
        rotor_init = 5'd7;
        step();
        set_rotor = 1'b0;
        m_rotor = 7; m_count = 0;
        repeat (3) begin step(); if (out_valid) pulses++; end
        key_press = 1'b0;
        repeat (2) begin step(); if (out_valid) pulses++; end
        check("coinc.pulses", pulses, 0);
        check("coinc.busy", int'(busy), 0);
        check_state("coinc");

        // Async reset between E0 and E1
        pulses    = 0;
        char_in   = "D";
        key_press = 1'b1;
        step();
        check("areset.busy_e0", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        m_rotor = 0; m_count = 0; m_enc = 0;
        check("areset.valid", int'(out_valid), 0);
        check("areset.busy", int'(busy), 0);
        check_state("areset");
        repeat (2) begin step(); if (out_valid) pulses++; end
        reset = 1'b1;
        repeat (5) begin step(); if (out_valid) pulses++; end
        check("areset.held_pulses", pulses, 0);
        check("areset.held_busy", int'(busy), 0);
        check_state("areset_held");
        key_press = 1'b0;
        repeat (2) step();
        press("B", 1, "after_rst");
        check("after_rst.lit", int'(enc_out), 66);

        // Randomized keypresses and occasional loads
        for (int n = 0; n < 40; n++) begin
            int sel;
            logic [7:0] c;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                load_rotor($urandom_range(0, 31));
            end else begin
                if (sel < 5)      c = 8'($urandom_range(65, 90));
                else if (sel < 9) c = 8'($urandom_range(97, 122));
                else              c = 8'($urandom_range(0, 255));
                press(c, $urandom_range(1, 4), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/caesar_stepper_encoder.md
# caesar_stepper_encoder

Encryption-side counterpart of the bombe deduction block. It accepts plaintext ASCII characters one keypress at a time and encrypts each letter with a rotor shift. The shift starts at a loaded setting and steps by one after every letter, wrapping 25→0. A plaintext `ABC` encrypted from rotor setting r yields exactly the 3-character flag the bombe resolves back to r. The block sits between the keyboard/switch input stage and the display/bombe input.

## Interface
Parameters:
- ROTOR_RESET, 0, rotor value forced by reset; legal range 0..25.

Ports:
- clk  in  1  system clock (CLOCK_50); all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately, independent of clk.
- char_in  in  8  plaintext ASCII character; captured on the accepted keypress edge.
- key_press  in  1  level-high keypress; already debounced and synchronous to clk.
- set_rotor  in  1  level; loads rotor from rotor_init while in IDLE.
- rotor_init  in  5  requested start setting; 26..31 are reduced by 26.
- enc_out  out  8  last ciphertext character; holds until the next encryption.
- out_valid  out  1  one-cycle pulse when enc_out is updated.
- rotor_out  out  5  current rotor value, 0..25.
- char_count  out  8  letters encrypted since the last set_rotor; saturates at 255.
- busy  out  1  high when the state is not IDLE.

## Operation
- key_q is a registered copy of key_press. Accepted edge = key_press=1 and key_q=0, sampled while in IDLE.
- FSM states: IDLE, ENCRYPT, WAIT_RELEASE.
  - IDLE, set_rotor=1: rotor ← rotor_init mod 26 and char_count ← 0. A simultaneous keypress edge is ignored.
  - IDLE, accepted edge (set_rotor=0): char_reg ← char_in; next state ENCRYPT.
  - ENCRYPT → WAIT_RELEASE unconditionally. This transition performs the encryption and update.
  - WAIT_RELEASE: stays while key_press=1; goes to IDLE when key_press is sampled 0.
- Encryption of char_reg c with rotor r:
  - Uppercase 65..90: out = 65 + ((c−65)+r) mod 26.
  - Lowercase 97..122: out = 97 + ((c−97)+r) mod 26.
  - Modulo: 6-bit sum; subtract 26 if the sum is ≥26.
  - Any other byte: out = c. Rotor and char_count are not changed.
- After encrypting a letter, rotor ← (r+1) mod 26 (25→0) and char_count increments, saturating at 255.
- set_rotor in ENCRYPT or WAIT_RELEASE is ignored (not queued).
- A held key produces exactly one encryption. A new one requires release to IDLE, then a new 0→1 edge.

## Timing
- Reset values (while reset=0):
  - state IDLE, key_q 0, char_reg 0.
  - enc_out 8'd0, out_valid 0, rotor_out ROTOR_RESET, char_count 0, busy 0.
- Edge E0 (first edge with key_press=1, key_q=0, state IDLE): char_in captured; busy=1 after E0.
- Edge E1: enc_out, rotor_out and char_count update; out_valid=1 from E1 until E2.
- Edge E2: out_valid returns to 0. Latency from E0 to valid output is 1 cycle.
- Minimum spacing between encryptions is 3 cycles plus the release time.
- set_rotor takes effect on the edge where it is sampled in IDLE; rotor_out shows the new value after that edge.
- If reset is asserted in any state (e.g., between E0 and E1), the block returns to reset values immediately: no out_valid, and the rotor is not stepped. After reset deasserts, a key already held high produces no encryption until it is released and pressed again.

## Test plan
- Basic sequence: reset; set_rotor with rotor_init=3; press A, B, C → enc_out 68 ('D'), 70 ('F'), 72 ('H'), one out_valid each; rotor_out=6; char_count=3.
- Wrap and case: rotor_init=25; press 'Z'(90) → 89 ('Y'), rotor_out=0; then press 'a'(97) → 97, rotor_out=1.
- Non-letter pass-through: rotor_init=5; press '1'(49) → enc_out=49, out_valid pulses, rotor_out stays 5, char_count stays 0.
- Held key: key_press held high 20 cycles with 'A', rotor 0 → exactly one out_valid, enc_out=65, busy=1 until the release is sampled.
- Load rules: rotor_init=30 in IDLE → rotor_out=4. set_rotor=1 with rotor_init=10 during WAIT_RELEASE → rotor_out unchanged. set_rotor coincident with a key edge in IDLE → rotor loaded, no encryption.
- Async reset mid-operation: reset driven 0 between E0 and E1 (no clk edge needed) → all outputs return to reset values at once, no out_valid. After reset deasserts with the key still held → no encryption until the key is released and pressed again.
